// File: rtl/pu_pkg.sv
// Shared definitions for the pipelined radix-2 butterfly unit: default widths,
// saturation limits, butterfly mode encoding and complex-word pack/unpack helpers.
package pu_pkg;

   localparam int DW_DEF    = 16;
   localparam int TW_DEF    = 20;
   localparam int TFRAC_DEF = 16;

   localparam logic signed [DW_DEF-1:0] SAT_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
   localparam logic signed [DW_DEF-1:0] SAT_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

   typedef enum logic {
      MODE_DIF = 1'b0,
      MODE_DIT = 1'b1
   } bfly_mode_e;

   function automatic logic [2*DW_DEF-1:0] cplx_pack(input logic signed [DW_DEF-1:0] re,
                                                     input logic signed [DW_DEF-1:0] im);
      return {re, im};
   endfunction

   function automatic logic signed [DW_DEF-1:0] cplx_re(input logic [2*DW_DEF-1:0] w);
      return w[2*DW_DEF-1:DW_DEF];
   endfunction

   function automatic logic signed [DW_DEF-1:0] cplx_im(input logic [2*DW_DEF-1:0] w);
      return w[DW_DEF-1:0];
   endfunction

endpackage

// File: rtl/pu_rndsat.sv
// Round-half-up arithmetic right shift by a run-time amount, then clamp one
// component to the signed OW-bit range, flagging when the clamp engaged.
module pu_rndsat
   import pu_pkg::*;
#(
   parameter int IW = 40,
   parameter int OW = DW_DEF,
   parameter int KW = 8
) (
   input  logic signed [IW-1:0] i_val,
   input  logic        [KW-1:0] i_k,
   output logic signed [OW-1:0] o_val,
   output logic                 o_sat
);

   localparam logic signed [IW:0] HI = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [IW:0] LO = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

   logic signed [IW:0] w_ext;
   logic signed [IW:0] w_half;
   logic signed [IW:0] w_sum;
   logic signed [IW:0] w_rnd;

   // One guard bit above IW keeps the rounding add from wrapping; k = 0 adds nothing.
   always_comb begin
      w_ext  = (IW+1)'(i_val);
      w_half = '0;
      if (i_k != '0) begin
         w_half = (IW+1)'(1) <<< (i_k - 1'b1);
      end
      w_sum = w_ext + w_half;
      w_rnd = w_sum >>> i_k;
      o_sat = 1'b0;
      o_val = w_rnd[OW-1:0];
      if (w_rnd > HI) begin
         o_val = HI[OW-1:0];
         o_sat = 1'b1;
      end else if (w_rnd < LO) begin
         o_val = LO[OW-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/pu_pipe.sv
// Three-stage pipelined radix-2 butterfly (DIF/DIT per transaction) with optional
// divide-by-2 scaling, saturation, sticky overflow and a global-stall valid/ready flow.
module pu_pipe
   import pu_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int TW    = TW_DEF,
   parameter int TFRAC = TFRAC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2*DW-1:0] x_in,
   input  logic [2*DW-1:0] y_in,
   input  logic [2*TW-1:0] w_in,
   input  logic          mode_dit,
   input  logic          scale,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2*DW-1:0] a_out,
   output logic [2*DW-1:0] b_out,
   output logic          out_sat,
   output logic          ovf,
   input  logic          ovf_clr
);

   localparam int AW = DW + 1;
   localparam int PW = AW + TW + 1;
   localparam int SW = PW + 2;
   localparam int KW = 8;

   logic w_en;
   logic r3_valid;

   logic signed [DW-1:0] w_xre, w_xim, w_yre, w_yim;
   logic signed [AW-1:0] w_s1_are, w_s1_aim, w_s1_dre, w_s1_dim;

   logic                 r1_valid, r1_scale;
   bfly_mode_e           r1_mode;
   logic signed [AW-1:0] r1_are, r1_aim, r1_dre, r1_dim;
   logic signed [TW-1:0] r1_wre, r1_wim;

   logic signed [PW-1:0] w_pre, w_pim;

   logic                 r2_valid, r2_scale;
   bfly_mode_e           r2_mode;
   logic signed [AW-1:0] r2_are, r2_aim;
   logic signed [PW-1:0] r2_pre, r2_pim;

   logic signed [SW-1:0] w_xs_re, w_xs_im, w_p_re, w_p_im;
   logic signed [SW-1:0] w_va_re, w_va_im, w_vb_re, w_vb_im;
   logic        [KW-1:0] w_k_a, w_k_b;
   logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
   logic        [3:0]    w_sat;
   logic                 w_sat_any;

   logic signed [DW-1:0] r3_are, r3_aim, r3_bre, r3_bim;
   logic                 r3_sat, r_ovf;

   assign w_en     = !r3_valid || out_ready;
   assign in_ready = w_en;

   // DIT reuses the A/D slots for X/Y so S2 always multiplies the D slot by W.
   always_comb begin
      w_xre = x_in[2*DW-1:DW];
      w_xim = x_in[DW-1:0];
      w_yre = y_in[2*DW-1:DW];
      w_yim = y_in[DW-1:0];
      if (mode_dit) begin
         w_s1_are = AW'(w_xre);
         w_s1_aim = AW'(w_xim);
         w_s1_dre = AW'(w_yre);
         w_s1_dim = AW'(w_yim);
      end else begin
         w_s1_are = AW'(w_xre) + AW'(w_yre);
         w_s1_aim = AW'(w_xim) + AW'(w_yim);
         w_s1_dre = AW'(w_xre) - AW'(w_yre);
         w_s1_dim = AW'(w_xim) - AW'(w_yim);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_scale <= 1'b0;
         r1_mode  <= MODE_DIF;
         r1_are   <= '0;
         r1_aim   <= '0;
         r1_dre   <= '0;
         r1_dim   <= '0;
         r1_wre   <= '0;
         r1_wim   <= '0;
      end else if (w_en) begin
         r1_valid <= in_valid;
         r1_scale <= scale;
         r1_mode  <= mode_dit ? MODE_DIT : MODE_DIF;
         r1_are   <= w_s1_are;
         r1_aim   <= w_s1_aim;
         r1_dre   <= w_s1_dre;
         r1_dim   <= w_s1_dim;
         r1_wre   <= w_in[2*TW-1:TW];
         r1_wim   <= w_in[TW-1:0];
      end
   end

   assign w_pre = PW'(r1_dre) * PW'(r1_wre) - PW'(r1_dim) * PW'(r1_wim);
   assign w_pim = PW'(r1_dre) * PW'(r1_wim) + PW'(r1_dim) * PW'(r1_wre);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r2_scale <= 1'b0;
         r2_mode  <= MODE_DIF;
         r2_are   <= '0;
         r2_aim   <= '0;
         r2_pre   <= '0;
         r2_pim   <= '0;
      end else if (w_en) begin
         r2_valid <= r1_valid;
         r2_scale <= r1_scale;
         r2_mode  <= r1_mode;
         r2_are   <= r1_are;
         r2_aim   <= r1_aim;
         r2_pre   <= w_pre;
         r2_pim   <= w_pim;
      end
   end

   always_comb begin
      w_xs_re = SW'(r2_are) <<< TFRAC;
      w_xs_im = SW'(r2_aim) <<< TFRAC;
      w_p_re  = SW'(r2_pre);
      w_p_im  = SW'(r2_pim);
      w_k_b   = KW'(TFRAC) + KW'(r2_scale);
      if (r2_mode == MODE_DIT) begin
         w_va_re = w_xs_re + w_p_re;
         w_va_im = w_xs_im + w_p_im;
         w_vb_re = w_xs_re - w_p_re;
         w_vb_im = w_xs_im - w_p_im;
         w_k_a   = w_k_b;
      end else begin
         w_va_re = SW'(r2_are);
         w_va_im = SW'(r2_aim);
         w_vb_re = w_p_re;
         w_vb_im = w_p_im;
         w_k_a   = KW'(r2_scale);
      end
   end

   pu_rndsat #(.IW(SW), .OW(DW), .KW(KW)) u_rs_are (
      .i_val(w_va_re), .i_k(w_k_a), .o_val(w_a_re), .o_sat(w_sat[0]));
   pu_rndsat #(.IW(SW), .OW(DW), .KW(KW)) u_rs_aim (
      .i_val(w_va_im), .i_k(w_k_a), .o_val(w_a_im), .o_sat(w_sat[1]));
   pu_rndsat #(.IW(SW), .OW(DW), .KW(KW)) u_rs_bre (
      .i_val(w_vb_re), .i_k(w_k_b), .o_val(w_b_re), .o_sat(w_sat[2]));
   pu_rndsat #(.IW(SW), .OW(DW), .KW(KW)) u_rs_bim (
      .i_val(w_vb_im), .i_k(w_k_b), .o_val(w_b_im), .o_sat(w_sat[3]));

   assign w_sat_any = r2_valid && (|w_sat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_valid <= 1'b0;
         r3_sat   <= 1'b0;
         r3_are   <= '0;
         r3_aim   <= '0;
         r3_bre   <= '0;
         r3_bim   <= '0;
      end else if (w_en) begin
         r3_valid <= r2_valid;
         r3_sat   <= w_sat_any;
         r3_are   <= w_a_re;
         r3_aim   <= w_a_im;
         r3_bre   <= w_b_re;
         r3_bim   <= w_b_im;
      end
   end

   // A saturating result landing in S3 outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_en && w_sat_any) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign out_valid = r3_valid;
   assign a_out     = {r3_are, r3_aim};
   assign b_out     = {r3_bre, r3_bim};
   assign out_sat   = r3_sat;
   assign ovf       = r_ovf;

endmodule
